// File: rtl/shift_sequencer.sv
// shift_sequencer: serial shift controller with request/response handshakes.
// Accepts one shift request in IDLE, shifts the operand one bit per clock in
// SHIFT, and presents the result in DONE until the consumer takes it.
// Optional feature macro: SHIFT_SEQ_ARITH_EN (op 2'b10 becomes arithmetic
// right shift; when undefined, op 2'b10 is a reserved pass-through with err).
module shift_sequencer #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       shiftControl,
  input  logic [15:0]      shamt,
  input  logic [WIDTH-1:0] data,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] out,
  output logic             err,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

`ifdef SHIFT_SEQ_ARITH_EN
  localparam logic ARITH_EN = 1'b1;
`else
  localparam logic ARITH_EN = 1'b0;
`endif

  state_t             state_r, state_s;
  logic [1:0]         op_r, op_s;
  logic [WIDTH-1:0]   work_r, work_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic               err_r, err_s;
  logic [CNT_W-1:0]   cnt_load_s;
  logic               no_shift_s;

  // One-position shift of the working operand for the latched op code.
  function automatic logic [WIDTH-1:0] shift_one(input logic [1:0] op_f,
                                                 input logic [WIDTH-1:0] w);
    case (op_f)
      2'b01:   shift_one = {w[WIDTH-2:0], 1'b0};
      2'b11:   shift_one = {1'b0, w[WIDTH-1:1]};
`ifdef SHIFT_SEQ_ARITH_EN
      2'b10:   shift_one = {w[WIDTH-1], w[WIDTH-1:1]};
`else
      2'b10:   shift_one = w;
`endif
      default: shift_one = w;
    endcase
  endfunction

  // Saturate the requested amount and decide whether any shifting is needed.
  always_comb begin
    cnt_load_s = {CNT_W{1'b0}};
    no_shift_s = 1'b0;
    if (shamt >= 16'(WIDTH)) begin
      cnt_load_s = CNT_W'(WIDTH);
    end else begin
      cnt_load_s = shamt[CNT_W-1:0];
    end
    no_shift_s = (shiftControl == 2'b00) ||
                 ((shiftControl == 2'b10) && !ARITH_EN) ||
                 (cnt_load_s == {CNT_W{1'b0}});
  end

  // Next-state and datapath update for the IDLE/SHIFT/DONE sequence.
  always_comb begin
    state_s = state_r;
    op_s    = op_r;
    work_s  = work_r;
    cnt_s   = cnt_r;
    err_s   = err_r;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          op_s   = shiftControl;
          work_s = data;
          cnt_s  = cnt_load_s;
          err_s  = (shiftControl == 2'b10) && !ARITH_EN;
          if (no_shift_s) begin
            state_s = DONE;
          end else begin
            state_s = SHIFT;
          end
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        work_s = shift_one(op_r, work_r);
        cnt_s  = cnt_r - CNT_W'(1);
        if (cnt_r == CNT_W'(1)) begin
          state_s = DONE;
        end else begin
          state_s = SHIFT;
        end
      end
      DONE: begin
        if (resp_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      op_r    <= 2'b00;
      work_r  <= {WIDTH{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      err_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      op_r    <= op_s;
      work_r  <= work_s;
      cnt_r   <= cnt_s;
      err_r   <= err_s;
    end
  end

  assign req_ready  = (state_r == IDLE);
  assign resp_valid = (state_r == DONE);
  assign busy       = (state_r != IDLE);
  assign out        = work_r;
  assign err        = err_r;

endmodule
